// File: rtl/riscv_defs.sv
// Shared definitions for the single-cycle RISC-V core: fetch state encoding,
// the canonical NOP and the base-ISA opcodes decoded by the control unit.
package riscv_defs;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_CNT_LO = 2'd0;
    localparam fetch_state_t FETCH_CNT_HI = 2'd1;
    localparam fetch_state_t FETCH_LOAD   = 2'd2;
    localparam fetch_state_t FETCH_RUN    = 2'd3;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imem.sv
// Instruction memory: one synchronous write port for the boot loader and one
// asynchronous read port so the fetched word follows the PC in the same cycle.
module imem #(
    parameter int IMEM_WORDS = 256,
    parameter int AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [IMEM_WORDS];

    // No reset on the array: a program survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: boot-loads a length-prefixed program from the UART byte stream
// into imem, then runs the PC and presents the current instruction and fields.
module instr_fetch
    import riscv_defs::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        pcsrc,
    input  logic [31:0] immext,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        run,
    output logic        load_err
);

    localparam int          AW    = $clog2(IMEM_WORDS);
    localparam logic [16:0] DEPTH = 17'(IMEM_WORDS);

    fetch_state_t state;
    logic [1:0]   byte_cnt;
    logic [23:0]  byte_buf;
    logic [7:0]   count_lo;
    logic [15:0]  word_count;
    logic [15:0]  word_idx;
    logic         word_done;
    logic         idx_in_range;
    logic         last_word;
    logic         mem_we;
    logic [31:0]  mem_rdata;

    assign word_done    = (state == FETCH_LOAD) && rx_valid && (byte_cnt == 2'd3);
    assign idx_in_range = ({1'b0, word_idx} < DEPTH);
    assign last_word    = (word_idx == word_count - 16'd1);
    assign mem_we       = rst_n && word_done && idx_in_range;

    imem #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx[AW-1:0]),
        .wdata ({rx_data, byte_buf}),
        .raddr (pc[AW+1:2]),
        .rdata (mem_rdata)
    );

    // pc only moves in RUN, so it sits at RESET_PC throughout loading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH_CNT_LO;
            byte_cnt   <= 2'd0;
            byte_buf   <= 24'd0;
            count_lo   <= 8'd0;
            word_count <= 16'd0;
            word_idx   <= 16'd0;
            load_err   <= 1'b0;
            pc         <= RESET_PC;
        end else begin
            case (state)
                FETCH_CNT_LO: begin
                    if (rx_valid) begin
                        count_lo <= rx_data;
                        state    <= FETCH_CNT_HI;
                    end
                end
                FETCH_CNT_HI: begin
                    if (rx_valid) begin
                        word_count <= {rx_data, count_lo};
                        state      <= ({rx_data, count_lo} == 16'd0) ? FETCH_RUN : FETCH_LOAD;
                    end
                end
                FETCH_LOAD: begin
                    if (rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        byte_buf <= {rx_data, byte_buf[23:8]};
                    end
                    // Overflowing words are still counted so the stream stays in step.
                    if (word_done) begin
                        word_idx <= word_idx + 16'd1;
                        if (!idx_in_range) begin
                            load_err <= 1'b1;
                        end
                        if (last_word) begin
                            state <= FETCH_RUN;
                        end
                    end
                end
                FETCH_RUN: begin
                    pc <= pcsrc ? (pc + immext) : (pc + 32'd4);
                end
                default: begin
                    state <= FETCH_CNT_LO;
                end
            endcase
        end
    end

    assign run    = (state == FETCH_RUN);
    assign instr  = run ? mem_rdata : NOP_INSTR;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[30];

endmodule
